// File: rtl/cpu_defs.sv
// Shared definitions for the instruction fetch path: default widths,
// reset address and the fetch FSM state encoding.
package cpu_defs;

  localparam int unsigned ADDR_WIDTH  = 8;
  localparam int unsigned INSTR_WIDTH = 15;
  localparam int unsigned RESET_ADDR  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: jump load has priority over increment,
// increment wraps modulo 2^ADDR_WIDTH.
module program_counter
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_WIDTH = cpu_defs::ADDR_WIDTH,
  parameter int unsigned RESET_ADDR = cpu_defs::RESET_ADDR
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_en,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic                  i_inc_en,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);

  logic [ADDR_WIDTH-1:0] r_pc;

  // PC update: jump target load, else post-fetch increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load_en) begin
      r_pc <= i_load_addr;
    end else if (i_inc_en) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: holds the PC, reads words from instruction memory
// over a req/ack handshake and delivers each with a one-cycle load strobe.
// A single-entry pending slot buffers one fetch request raised while busy.
module instruction_fetch
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_WIDTH  = cpu_defs::ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = cpu_defs::INSTR_WIDTH,
  parameter int unsigned RESET_ADDR  = cpu_defs::RESET_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   next,
  input  logic                   jump_en,
  input  logic [ADDR_WIDTH-1:0]  jump_addr,
  input  logic                   halt,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_load,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   busy
);

  fetch_state_t           r_state;
  logic                   r_mem_req;
  logic                   r_instr_load;
  logic                   r_busy;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_pending;
  logic                   r_pending_jump;
  logic [ADDR_WIDTH-1:0]  r_pending_addr;

  logic                   w_accept_idle;
  logic                   w_accept_load;
  logic                   w_jump_sel;
  logic [ADDR_WIDTH-1:0]  w_jump_target;
  logic                   w_pc_load;
  logic                   w_pc_inc;
  logic [ADDR_WIDTH-1:0]  w_pc;

  // Start-of-fetch decisions and jump target selection. In IDLE a fresh
  // next takes precedence over an older retained pending request.
  always_comb begin
    w_accept_idle = (r_state == IDLE) && (next || r_pending) && !halt;
    w_accept_load = (r_state == LOAD) && r_pending && !halt;
    w_jump_sel    = r_pending_jump;
    w_jump_target = r_pending_addr;
    if ((r_state == IDLE) && next) begin
      w_jump_sel    = jump_en;
      w_jump_target = jump_addr;
    end
    w_pc_load = (w_accept_idle || w_accept_load) && w_jump_sel;
    w_pc_inc  = (r_state == REQ) && mem_ack;
  end

  program_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_ADDR(RESET_ADDR)
  ) u_pc (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load_en  (w_pc_load),
    .i_load_addr(w_jump_target),
    .i_inc_en   (w_pc_inc),
    .o_pc       (w_pc)
  );

  // Fetch FSM with registered outputs and pending-request bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_mem_req      <= 1'b0;
      r_instr_load   <= 1'b0;
      r_busy         <= 1'b0;
      r_instr        <= '0;
      r_pending      <= 1'b0;
      r_pending_jump <= 1'b0;
      r_pending_addr <= '0;
    end else begin
      r_instr_load <= 1'b0;
      case (r_state)
        IDLE: begin
          // next under halt is dropped; a retained pending stays put.
          if (w_accept_idle) begin
            r_state   <= REQ;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
          end
        end
        REQ: begin
          if (next) begin
            r_pending      <= 1'b1;
            r_pending_jump <= jump_en;
            r_pending_addr <= jump_addr;
          end
          if (mem_ack) begin
            r_instr      <= mem_data;
            r_instr_load <= 1'b1;
            r_mem_req    <= 1'b0;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          if (w_accept_load) begin
            r_state   <= REQ;
            r_mem_req <= 1'b1;
            r_pending <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          // A next in the consuming cycle re-arms the slot (overrides clear).
          if (next) begin
            r_pending      <= 1'b1;
            r_pending_jump <= jump_en;
            r_pending_addr <= jump_addr;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = w_pc;
  assign pc         = w_pc;
  assign instr      = r_instr;
  assign instr_load = r_instr_load;
  assign busy       = r_busy;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus pushes expected
// fetches, a memory responder acks requests, a monitor checks each load.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        next;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halt;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [14:0] mem_data;
  logic [14:0] instr;
  logic        instr_load;
  logic [7:0]  pc;
  logic        busy;

  logic        resp_ack = 1'b0;
  logic [14:0] resp_data = '0;
  logic        force_ack;
  logic [14:0] force_data;
  logic        resp_en;
  int          ack_wait;
  int          wait_cnt = 0;
  int          cyc = 0;
  logic        prev_req = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [14:0] data;
    logic [7:0]  pc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ack_addr_q[$];
  int         load_cyc_q[$];
  int         rise_cyc_q[$];

  assign mem_ack  = resp_ack | force_ack;
  assign mem_data = force_ack ? force_data : resp_data;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  instruction_fetch #(
    .ADDR_WIDTH(8),
    .INSTR_WIDTH(15),
    .RESET_ADDR(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .halt      (halt),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .instr     (instr),
    .instr_load(instr_load),
    .pc        (pc),
    .busy      (busy)
  );

  function automatic logic [14:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   mem_word = 15'h1A5A;
      8'hFF:   mem_word = 15'h7FFF;
      default: mem_word = 15'h4000 | {7'b0, a};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [14:0] d, input logic [7:0] p);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk(name, {31'b0, done}, 32'd1);
  endtask

  // Memory model: acks ack_wait cycles into each request.
  always @(negedge clk) begin
    if (resp_en && mem_req) begin
      if (wait_cnt == ack_wait) begin
        resp_ack  = 1'b1;
        resp_data = mem_word(mem_addr);
        ack_addr_q.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: compare every load strobe against the scoreboard.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] a;
    if (mem_req && !prev_req) rise_cyc_q.push_back(cyc);
    prev_req = mem_req;
    if (instr_load) begin
      load_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_load: instr=%0h with no fetch outstanding", instr);
      end else begin
        e = exp_q.pop_front();
        a = (ack_addr_q.size() > 0) ? ack_addr_q.pop_front() : 8'hxx;
        chk("load_addr", {24'b0, a}, {24'b0, e.addr});
        chk("load_instr", {17'b0, instr}, {17'b0, e.data});
        chk("load_pc", {24'b0, pc}, {24'b0, e.pc});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b1; next = 1'b0; jump_en = 1'b0; jump_addr = '0; halt = 1'b0;
    force_ack = 1'b0; force_data = '0; resp_en = 1'b1; ack_wait = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_instr_load", {31'b0, instr_load}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_pc", {24'b0, pc}, 32'd0);
    chk("rst_instr", {17'b0, instr}, 32'd0);
    reset = 1'b0;

    // Plain fetch, ack in second REQ cycle.
    ack_wait = 1;
    load_cyc_q.delete();
    push_exp(8'h00, 15'h1A5A, 8'h01);
    @(negedge clk); next = 1'b1; t0 = cyc;
    @(negedge clk); next = 1'b0;
    chk("t1_req_addr", {24'b0, mem_addr}, 32'd0);
    wait_drain("t1_drain");
    chk("t1_nloads", load_cyc_q.size(), 32'd1);
    if (load_cyc_q.size() > 0) chk("t1_latency", load_cyc_q[0] - t0, 32'd3);
    chk("t1_instr_hold", {17'b0, instr}, 32'h1A5A);

    // Jump to FF, pc wraps to 0 after the fetch.
    ack_wait = 0;
    push_exp(8'hFF, 15'h7FFF, 8'h00);
    @(negedge clk); next = 1'b1; jump_en = 1'b1; jump_addr = 8'hFF;
    @(negedge clk); next = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
    chk("t2_req", {31'b0, mem_req}, 32'd1);
    chk("t2_req_addr", {24'b0, mem_addr}, 32'hFF);
    wait_drain("t2_drain");
    chk("t2_pc_wrap", {24'b0, pc}, 32'd0);

    // Three nexts during one REQ collapse into a single pending fetch.
    ack_wait = 8;
    load_cyc_q.delete();
    rise_cyc_q.delete();
    push_exp(8'h00, 15'h1A5A, 8'h01);
    push_exp(8'h01, 15'h4001, 8'h02);
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); next = 1'b1;
      @(negedge clk); next = 1'b0;
    end
    wait_drain("t3_drain");
    chk("t3_nloads", load_cyc_q.size(), 32'd2);
    chk("t3_nrises", rise_cyc_q.size(), 32'd2);
    if (load_cyc_q.size() > 0 && rise_cyc_q.size() > 1)
      chk("t3_req_after_load", rise_cyc_q[1] - load_cyc_q[0], 32'd1);

    // next under halt in IDLE is dropped.
    halt = 1'b1;
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_halt_req", {31'b0, mem_req}, 32'd0);
    chk("t4_halt_busy", {31'b0, busy}, 32'd0);
    halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_dropped_busy", {31'b0, busy}, 32'd0);
    chk("t4_dropped_pc", {24'b0, pc}, 32'd2);

    // halt raised mid-REQ: first fetch completes, pending waits for halt low.
    ack_wait = 3;
    push_exp(8'h02, 15'h4002, 8'h03);
    push_exp(8'h03, 15'h4003, 8'h04);
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    @(negedge clk); next = 1'b1; halt = 1'b1;
    @(negedge clk); next = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_held_busy", {31'b0, busy}, 32'd0);
    chk("t4_held_req", {31'b0, mem_req}, 32'd0);
    chk("t4_held_instr", {17'b0, instr}, 32'h4002);
    chk("t4_held_pc", {24'b0, pc}, 32'd3);
    chk("t4_held_outstanding", exp_q.size(), 32'd1);
    halt = 1'b0;
    wait_drain("t4_drain");
    chk("t4_pc", {24'b0, pc}, 32'd4);

    // Asynchronous reset mid-REQ, then a stray ack in IDLE.
    resp_en = 1'b0;
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    @(negedge clk);
    chk("t5_req_before", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_req", {31'b0, mem_req}, 32'd0);
    chk("t5_async_instr", {17'b0, instr}, 32'd0);
    chk("t5_async_load", {31'b0, instr_load}, 32'd0);
    chk("t5_async_pc", {24'b0, pc}, 32'd0);
    chk("t5_async_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;
    ack_addr_q.delete();
    force_data = 15'h2222; force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("t5_late_ack_instr", {17'b0, instr}, 32'd0);
    chk("t5_late_ack_pc", {24'b0, pc}, 32'd0);
    chk("t5_late_ack_busy", {31'b0, busy}, 32'd0);
    resp_en = 1'b1;

    // next held high, zero-wait ack: one load every second cycle.
    ack_wait = 0;
    load_cyc_q.delete();
    push_exp(8'h00, 15'h1A5A, 8'h01);
    push_exp(8'h01, 15'h4001, 8'h02);
    push_exp(8'h02, 15'h4002, 8'h03);
    push_exp(8'h03, 15'h4003, 8'h04);
    @(negedge clk); next = 1'b1;
    repeat (6) @(negedge clk);
    next = 1'b0;
    wait_drain("t6_drain");
    chk("t6_nloads", load_cyc_q.size(), 32'd4);
    for (int k = 1; k < load_cyc_q.size(); k++)
      chk("t6_spacing", load_cyc_q[k] - load_cyc_q[k-1], 32'd2);

    repeat (2) @(negedge clk);
    chk("end_outstanding", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Producer side of the instruction register's load interface: holds the program counter, reads 15-bit instruction words from instruction memory over a req/ack handshake, and delivers each word with a one-cycle load strobe.
- `instr_load` drives the instruction register's `increment` input; `instr` drives its `instruction` input.
- The control unit requests each fetch with `next`, optionally redirecting the PC with `jump_en` / `jump_addr`.

Parameters:
- ADDR_WIDTH, 8, width of PC and memory address.
- INSTR_WIDTH, 15, instruction word width; must equal the instruction register width.
- RESET_ADDR, 0, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- next  in  1  fetch request pulse from control unit
- jump_en  in  1  qualifies `next`: fetch from jump_addr instead of pc
- jump_addr  in  ADDR_WIDTH  redirect target
- halt  in  1  level; blocks starting new fetches
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_WIDTH  read address (= pc register)
- mem_ack  in  1  memory has `mem_data` valid this cycle
- mem_data  in  INSTR_WIDTH  read data
- instr  out  INSTR_WIDTH  registered fetched instruction
- instr_load  out  1  one-cycle strobe, `instr` valid
- pc  out  ADDR_WIDTH  current program counter
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (asynchronous, immediate, also mid-transaction):
  - state IDLE, pc = RESET_ADDR, `mem_req` 0, `instr` 0, `instr_load` 0, `busy` 0.
  - pending 0, pending_jump 0, pending_addr 0.
- FSM states: IDLE, REQ, LOAD.
- IDLE:
  - Leaves only if (`next` or pending) and !`halt`, going to REQ.
  - If the accepted request carries a jump (`jump_en` with `next`, or pending_jump), pc <= target on that edge.
  - pending is cleared on that edge.
  - `next` while `halt`=1 is dropped; it is not stored.
- REQ:
  - `mem_req` = 1 and `mem_addr` = pc, both stable until ack.
  - On `mem_ack`=1: `instr` <= `mem_data`, pc <= pc+1 (modulo 2^ADDR_WIDTH; all-ones wraps to 0), go to LOAD.
  - `mem_req` is low in LOAD.
  - Unbounded wait for ack; `mem_ack` outside REQ is ignored.
- LOAD:
  - `instr_load` = 1 for exactly this cycle.
  - Next state: REQ if pending and !`halt` (jump applied as in IDLE, pending cleared); otherwise IDLE.
- Pending request:
  - `next` in REQ or LOAD sets pending, and latches `jump_en` into pending_jump and `jump_addr` into pending_addr. One deep.
  - A second `next` while pending is already set overwrites the jump info (last request wins).
  - `next` in the same LOAD cycle that consumes pending also counts: it re-sets pending.
- `halt` never aborts an in-flight REQ; it only gates the IDLE->REQ and LOAD->REQ transitions. A retained pending request resumes when `halt` falls.
- Latency, with ack k cycles after request:
  - `next` at edge t: `mem_req` high from t+1.
  - `mem_ack` at cycle t+k: `instr_load` high in cycle t+k+1.
  - Minimum `next`-to-`instr_load` is 2 cycles (ack in first REQ cycle).
- Back-to-back: with `next` held high and ack in 0 wait, one instruction every 2 cycles (REQ, LOAD alternate).
- `instr` holds its value between loads.
- `pc` always shows the next address to fetch (post-increment).

Decomposition:
- Shared package `cpu_defs`:
  - INSTR_WIDTH and ADDR_WIDTH defaults.
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, LOAD=2'd2).
  - RESET_ADDR constant.
- One sub-module is natural: `program_counter`, holding the pc register with load (jump) / increment / async reset.
- FSM and pending logic stay in instruction_fetch.

Test Plan:
- Reset then `next` pulse, memory acks in 2nd REQ cycle with 15'h1A5A -> `mem_addr`=0 during REQ; `instr`=15'h1A5A with `instr_load` high for exactly one cycle, 3 cycles after `next`; pc=1.
- `next` with `jump_en`=1, `jump_addr`=8'hFF, ack with 15'h7FFF -> `mem_addr`=FF in REQ; `instr`=7FFF; pc wraps to 8'h00.
- `next` pulsed again while in REQ, then twice more before ack -> exactly two fetches (addresses n, n+1); second `mem_req` rises the cycle after the first `instr_load`.
- `halt`=1 with `next` pulse in IDLE -> no `mem_req`, `busy`=0. Then `next` in REQ with `halt` raised before ack -> first fetch completes; second waits until `halt`=0, then fetches.
- Assert `reset` in REQ while `mem_req`=1 -> `mem_req`, `instr`, `instr_load` drop to 0 without a clock edge; pc=RESET_ADDR; late `mem_ack` ignored.
- `next` held high continuously, ack in 0 wait -> `instr_load` every 2nd cycle, addresses 0,1,2,3 in order.
